stack_ctrl: RTL
===============

Name: stack_ctrl

Overview:
- LIFO stack controller for the data-memory side of the Harvard MIPS: serves push/pop requests from the execute/mem stage (register spills, CALL/RET return addresses).
- Owns a descending stack pointer and a 16-bit-wide stack RAM.
- 32-bit values (return PCs) are split into two 16-bit words over two cycles.
- Reports full/empty and sticky overflow/underflow errors to the control unit.

Parameters:
ADDR_W, 10, stack RAM address width; RAM depth 2^ADDR_W words of 16 bits; usable capacity 2^ADDR_W - 1 words.

Ports:
clk  in  1  single system clock; all state updates on rising edge.
rst  in  1  reset; asynchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request this cycle.
req_op  in  2  00 PUSH16, 01 POP16, 10 PUSH32, 11 POP32.
wr_data  in  32  push data; PUSH16 uses [15:0].
rd_data  out  32  pop result; POP16 zero-extends to 32 bits.
rd_valid  out  1  one-cycle pulse; rd_data is valid.
sp  out  ADDR_W  stack pointer: next free slot.
full  out  1  sp == 0.
empty  out  1  sp == all ones.
err_ovf  out  1  sticky: a push was refused for lack of space.
err_unf  out  1  sticky: a pop was refused for lack of data.
clr_err  in  1  synchronous clear of both sticky error flags.

Behaviour:
- Reset (async):
  - sp = all ones; state IDLE; req_ready=1.
  - rd_valid=0; rd_data=0; err_ovf=0; err_unf=0; empty=1; full=0.
  - RAM contents are not reset.
- Occupancy: count = (2^ADDR_W-1) - sp; free = sp. Stored words live at sp+1..2^ADDR_W-1.
- Accept: a request is accepted when req_valid & req_ready. req_ready=1 only in IDLE; req_valid and req_op are ignored otherwise.
- States: IDLE, PUSH_LO, POP_HI.
- PUSH16:
  - Requires free>=1.
  - In the acceptance cycle: mem[sp]<=wr_data[15:0]; sp<=sp-1. Stays in IDLE.
- PUSH32:
  - Requires free>=2.
  - Acceptance cycle: mem[sp]<=wr_data[31:16]; sp<=sp-1; wr_data[15:0] latched internally; ->PUSH_LO.
  - PUSH_LO: mem[sp]<=latched low half; sp<=sp-1; ->IDLE.
  - The low half ends on top.
- POP16:
  - Requires count>=1.
  - Acceptance cycle: RAM reads sp+1; sp<=sp+1.
  - Next cycle: rd_data={16'h0, word}; rd_valid=1.
  - Latency 1.
- POP32:
  - Requires count>=2.
  - Acceptance cycle: read low half at sp+1; sp<=sp+1; ->POP_HI.
  - POP_HI: read high half at sp+1; sp<=sp+1; ->IDLE.
  - Following cycle: rd_data={hi,lo}; rd_valid=1.
  - Latency 2; a new request may be accepted in the same cycle rd_valid is high.
- Refused requests:
  - Push without enough space: no RAM write, sp unchanged, no state change, err_ovf<=1.
  - Pop without enough data: err_unf<=1; rd_valid stays 0.
  - A PUSH32 with free==1 writes nothing (all-or-nothing).
- Error flags: clr_err clears both flags. If clr_err coincides with a new refusal, the set wins.
- rd_data holds its last value until the next pop completes.
- sp never wraps: full/empty checks precede every update.
- Reset mid-operation (PUSH_LO or POP_HI):
  - Aborts the operation; sp returns to all ones (stack empty).
  - A partially written high half remains in RAM but is unreachable.
  - rd_valid is not asserted.
- One RAM access per cycle: single port, synchronous write and synchronous read.

Decomposition:
- Package stack_pkg:
  - op encodings OP_PUSH16/OP_POP16/OP_PUSH32/OP_POP32.
  - state enum {IDLE, PUSH_LO, POP_HI}.
  - HALF_W=16.
- Sub-module stack_ram: single-port, 2^ADDR_W x 16, synchronous write (we) and registered read.
- stack_ctrl holds the FSM, sp, flags and output registers.

Test Plan (ADDR_W=3, capacity 7):
- Reset, then PUSH16 0x1111, PUSH16 0x2222, POP16, POP16 -> rd_data 0x00002222 then 0x00001111, each with rd_valid one cycle after acceptance; sp 7->5->7; empty=1 at end.
- PUSH32 0xDEADBEEF -> req_ready=0 for one cycle, sp=5. POP32 -> rd_valid 2 cycles after acceptance, rd_data=0xDEADBEEF, sp=7.
- Seven PUSH16 -> full=1, sp=0. An eighth push -> sp stays 0 and err_ovf=1. clr_err -> err_ovf=0.
- Six PUSH16 (free=1), then PUSH32 -> refused, no write, sp=1, err_ovf=1. A following POP16 returns the sixth word.
- Empty stack, POP32 -> err_unf=1, no rd_valid, sp=7. Assert clr_err in the same cycle as a second refused POP16 -> err_unf stays 1.
- PUSH32 0xCAFE0001 with rst asserted during PUSH_LO -> immediate sp=7, empty=1, state IDLE, req_ready=1; a subsequent POP16 raises err_unf.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared encodings for the LIFO stack controller.
package stack_pkg;

  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    OP_PUSH16 = 2'b00,
    OP_POP16  = 2'b01,
    OP_PUSH32 = 2'b10,
    OP_POP32  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PUSH_LO = 2'b01,
    POP_HI  = 2'b10
  } state_e;

endpackage

// File: rtl/stack_ram.sv
// Single-port stack RAM: synchronous write, registered read, no reset on contents.
module stack_ram
  import stack_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [HALF_W-1:0] wdata,
  output logic [HALF_W-1:0] rdata
);

  logic [HALF_W-1:0] mem [2**ADDR_W];

  // One access per cycle; the read register holds when not reading.
  always_ff @(posedge clk) begin
    if (we)      mem[addr] <= wdata;
    else if (re) rdata     <= mem[addr];
  end

endmodule

// File: rtl/stack_ctrl.sv
// LIFO stack controller: descending sp, 16-bit RAM, 32-bit values split in two halves.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] sp,
  output logic              full,
  output logic              empty,
  output logic              err_ovf,
  output logic              err_unf,
  input  logic              clr_err
);

  localparam logic [ADDR_W-1:0] SP_TOP = '1;
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO    = ADDR_W'(2);

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   sp_nxt, count;
  logic                ram_we, ram_re;
  logic [ADDR_W-1:0]   ram_addr;
  logic [HALF_W-1:0]   ram_wdata, ram_q;
  logic [HALF_W-1:0]   half_q;      // low half of a PUSH32, or low half read by a POP32
  logic                half_ld_push, half_ld_pop;
  logic                set_ovf, set_unf;
  logic                pop_go, pop_wide;
  logic                rd_wide;
  logic [31:0]         rd_hold;

  assign count = SP_TOP - sp;
  assign full  = (sp == '0);
  assign empty = (sp == SP_TOP);

  stack_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // Next state, sp update, RAM controls and refusal detection.
  always_comb begin
    state_nxt    = state;
    sp_nxt       = sp;
    req_ready    = (state == IDLE);
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_addr     = sp;
    ram_wdata    = wr_data[HALF_W-1:0];
    half_ld_push = 1'b0;
    half_ld_pop  = 1'b0;
    set_ovf      = 1'b0;
    set_unf      = 1'b0;
    pop_go       = 1'b0;
    pop_wide     = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        case (op_e'(req_op))
          OP_PUSH16: begin
            if (sp >= ONE) begin
              ram_we = 1'b1;
              sp_nxt = sp - ONE;
            end else set_ovf = 1'b1;
          end
          OP_PUSH32: begin
            // All-or-nothing: both halves must fit before anything is written.
            if (sp >= TWO) begin
              ram_we       = 1'b1;
              ram_wdata    = wr_data[31:HALF_W];
              sp_nxt       = sp - ONE;
              half_ld_push = 1'b1;
              state_nxt    = PUSH_LO;
            end else set_ovf = 1'b1;
          end
          OP_POP16: begin
            if (count >= ONE) begin
              ram_re   = 1'b1;
              ram_addr = sp + ONE;
              sp_nxt   = sp + ONE;
              pop_go   = 1'b1;
            end else set_unf = 1'b1;
          end
          OP_POP32: begin
            if (count >= TWO) begin
              ram_re    = 1'b1;
              ram_addr  = sp + ONE;
              sp_nxt    = sp + ONE;
              state_nxt = POP_HI;
            end else set_unf = 1'b1;
          end
          default: ;
        endcase
      end
      PUSH_LO: begin
        ram_we    = 1'b1;
        ram_wdata = half_q;
        sp_nxt    = sp - ONE;
        state_nxt = IDLE;
      end
      POP_HI: begin
        // ram_q holds the low half read last cycle; park it while the high half is read.
        ram_re      = 1'b1;
        ram_addr    = sp + ONE;
        sp_nxt      = sp + ONE;
        half_ld_pop = 1'b1;
        pop_go      = 1'b1;
        pop_wide    = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, stack pointer and half-word staging register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sp     <= SP_TOP;
      half_q <= '0;
    end else begin
      state <= state_nxt;
      sp    <= sp_nxt;
      if (half_ld_push)     half_q <= wr_data[HALF_W-1:0];
      else if (half_ld_pop) half_q <= ram_q;
    end
  end

  // Pop completion pulse; rd_data is held once the pulse has passed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_wide  <= 1'b0;
      rd_hold  <= '0;
    end else begin
      rd_valid <= pop_go;
      rd_wide  <= pop_wide;
      if (rd_valid) rd_hold <= rd_data;
    end
  end

  // The RAM read lands the cycle the pulse is high, so fresh data bypasses the hold register.
  assign rd_data = !rd_valid ? rd_hold :
                   rd_wide   ? {ram_q, half_q} : {16'h0000, ram_q};

  // Sticky error flags; a new refusal beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (set_ovf)      err_ovf <= 1'b1;
      else if (clr_err) err_ovf <= 1'b0;
      if (set_unf)      err_unf <= 1'b1;
      else if (clr_err) err_unf <= 1'b0;
    end
  end

endmodule
